// File: rtl/output_mem_pkg.sv
//------------------------------------------------------------------------------
// output_mem_pkg : shared FSM state encoding and size defaults for the
//                  rotate engine pixel buffers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package output_mem_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int AW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_mem_ctrl.sv
//------------------------------------------------------------------------------
// output_mem_ctrl : IDLE/FILL/DRAIN sequencer, byte counters, frame size latch
//                   and READY/VALID/DONE generation for output_mem.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module output_mem_ctrl
    import output_mem_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_frame_bytes,
    input  logic          i_wr_en,
    input  logic          i_rd_en,
    output logic          o_wr_ready,
    output logic          o_rd_ready,
    output logic          o_start_accept,
    output logic          o_wr_accept,
    output logic          o_rd_accept,
    output logic          o_rd_valid,
    output logic          o_done
);

    localparam int CNT_W = AW + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_frame_sz;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   w_wr_sum;
    logic [CNT_W-1:0]   w_rd_sum;
    logic [CNT_W-1:0]   w_frame_ext;
    logic               w_rd_last;
    logic               r_rd_valid;
    logic               r_done;

    assign w_wr_sum    = r_wr_cnt + CNT_W'(3);
    assign w_rd_sum    = r_rd_cnt + CNT_W'(4);
    assign w_frame_ext = {1'b0, r_frame_sz};

    assign o_wr_ready  = (r_state == ST_FILL);
    assign o_rd_ready  = (r_state == ST_DRAIN);
    assign o_rd_valid  = r_rd_valid;
    assign o_done      = r_done;

    always_comb begin
        w_state_nxt    = r_state;
        o_start_accept = 1'b0;
        o_wr_accept    = 1'b0;
        o_rd_accept    = 1'b0;
        w_rd_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    o_start_accept = 1'b1;
                    w_state_nxt    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (i_wr_en) begin
                    o_wr_accept = 1'b1;
                    if (w_wr_sum >= w_frame_ext) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_rd_en) begin
                    o_rd_accept = 1'b1;
                    if (w_rd_sum >= w_frame_ext) begin
                        w_rd_last   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_frame_sz <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= o_rd_accept;
            // DONE shares the edge that publishes the final word
            r_done     <= w_rd_last;
            if (o_start_accept) begin
                r_frame_sz <= i_frame_bytes;
                r_wr_cnt   <= '0;
                r_rd_cnt   <= '0;
            end
            if (o_wr_accept) begin
                r_wr_cnt <= w_wr_sum;
            end
            if (o_rd_accept) begin
                r_rd_cnt <= w_rd_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_mem.sv
//------------------------------------------------------------------------------
// output_mem : output frame buffer; scattered B/G/R triple writes, packed
//              32-bit word reads. Optional O_ERR port via OUTPUT_MEM_ERR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module output_mem
    import output_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          I_HCLK,
    input  logic          I_HRESET_N,
    input  logic          I_START,
    input  logic [AW-1:0] I_FRAME_BYTES,
    input  logic          I_PIXEL_WR_EN,
    input  logic [AW-1:0] I_PIXEL_WR_ADDRB,
    input  logic [AW-1:0] I_PIXEL_WR_ADDRG,
    input  logic [AW-1:0] I_PIXEL_WR_ADDRR,
    input  logic [7:0]    I_PIXEL_B,
    input  logic [7:0]    I_PIXEL_G,
    input  logic [7:0]    I_PIXEL_R,
    input  logic          I_RD_EN,
    input  logic [AW-1:0] I_PIXEL_RD_ADDR0,
    input  logic [AW-1:0] I_PIXEL_RD_ADDR1,
    input  logic [AW-1:0] I_PIXEL_RD_ADDR2,
    input  logic [AW-1:0] I_PIXEL_RD_ADDR3,
    output logic [31:0]   O_HRDATA,
    output logic          O_RD_VALID,
    output logic          O_WR_READY,
    output logic          O_RD_READY,
`ifdef OUTPUT_MEM_ERR_EN
    output logic          O_ERR,
`endif
    output logic          O_DONE
);

    localparam int IW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [31:0]   r_hrdata;
    logic [AW-1:0] w_rd_addr [4];
    logic [7:0]    w_lane [4];
    logic [3:0]    w_lane_ok;
    logic          w_start_accept;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_b_ok;
    logic          w_g_ok;
    logic          w_r_ok;

    output_mem_ctrl #(
        .AW (AW)
    ) u_ctrl (
        .i_clk          (I_HCLK),
        .i_rst_n        (I_HRESET_N),
        .i_start        (I_START),
        .i_frame_bytes  (I_FRAME_BYTES),
        .i_wr_en        (I_PIXEL_WR_EN),
        .i_rd_en        (I_RD_EN),
        .o_wr_ready     (O_WR_READY),
        .o_rd_ready     (O_RD_READY),
        .o_start_accept (w_start_accept),
        .o_wr_accept    (w_wr_accept),
        .o_rd_accept    (w_rd_accept),
        .o_rd_valid     (O_RD_VALID),
        .o_done         (O_DONE)
    );

    assign w_b_ok = addr_ok(32'(I_PIXEL_WR_ADDRB), DEPTH);
    assign w_g_ok = addr_ok(32'(I_PIXEL_WR_ADDRG), DEPTH);
    assign w_r_ok = addr_ok(32'(I_PIXEL_WR_ADDRR), DEPTH);

    // Later assignments win, giving R > G > B on colliding addresses
    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_wr_accept) begin
            if (w_b_ok) r_mem[I_PIXEL_WR_ADDRB[IW-1:0]] <= I_PIXEL_B;
            if (w_g_ok) r_mem[I_PIXEL_WR_ADDRG[IW-1:0]] <= I_PIXEL_G;
            if (w_r_ok) r_mem[I_PIXEL_WR_ADDRR[IW-1:0]] <= I_PIXEL_R;
        end
    end

    assign w_rd_addr[0] = I_PIXEL_RD_ADDR0;
    assign w_rd_addr[1] = I_PIXEL_RD_ADDR1;
    assign w_rd_addr[2] = I_PIXEL_RD_ADDR2;
    assign w_rd_addr[3] = I_PIXEL_RD_ADDR3;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane_ok[g] = addr_ok(32'(w_rd_addr[g]), DEPTH);
        assign w_lane[g]    = w_lane_ok[g] ? r_mem[w_rd_addr[g][IW-1:0]] : 8'h00;
    end

    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            r_hrdata <= 32'h0;
        end else if (w_rd_accept) begin
            r_hrdata <= {w_lane[3], w_lane[2], w_lane[1], w_lane[0]};
        end
    end

    assign O_HRDATA = r_hrdata;

`ifdef OUTPUT_MEM_ERR_EN
    logic r_err;
    logic w_wr_coll;
    logic w_err_evt;

    assign w_wr_coll = (I_PIXEL_WR_ADDRB == I_PIXEL_WR_ADDRG) ||
                       (I_PIXEL_WR_ADDRB == I_PIXEL_WR_ADDRR) ||
                       (I_PIXEL_WR_ADDRG == I_PIXEL_WR_ADDRR);

    assign w_err_evt = (I_PIXEL_WR_EN && (!O_WR_READY || !w_b_ok || !w_g_ok || !w_r_ok || w_wr_coll)) ||
                       (I_RD_EN && (!O_RD_READY || (w_lane_ok != 4'hF)));

    // A new frame clears the flag, but an event in the start cycle still counts
    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            r_err <= 1'b0;
        end else if (w_start_accept) begin
            r_err <= w_err_evt;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign O_ERR = r_err;
`endif

endmodule

`default_nettype wire
